// File: rtl/intersection_pkg.sv
// Shared types and constants for the intersection phase timers.
package intersection_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam int unsigned CLK_HZ_DEFAULT  = 50_000_000;
  localparam int unsigned PHASE_SHORT_SEC = 5;
  localparam int unsigned PHASE_LONG_SEC  = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-CLK_HZ cycle counter producing a one-per-second enable tick.
module tick_prescaler #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] CNT_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] cnt;

  // Combinational so the owning FSM can act on the wrap in the same cycle
  assign tick = en && (cnt == CNT_MAX);

  always_ff @(posedge CLOCK_50) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable seconds timer with pause, restart and auto-reload.
module interval_timer
  import intersection_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned SEC_W  = 6
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             auto_reload,
  input  logic             pause,
  output logic             busy,
  output logic             done,
  output logic             tick_1hz,
  output logic [SEC_W-1:0] sec_left
);

  timer_state_t     state;
  logic [SEC_W-1:0] duration;
  logic             presc_en;
  logic             presc_tick;

  // A start always wins over counting, so the prescaler is held while it is applied
  assign presc_en = (state == RUN) && !pause && !start;

  tick_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clr     (start),
    .en      (presc_en),
    .tick    (presc_tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      duration <= '0;
      sec_left <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tick_1hz <= 1'b0;
    end else begin
      done     <= 1'b0;
      tick_1hz <= 1'b0;
      if (start) begin
        if (load_sec != '0) begin
          duration <= load_sec;
          sec_left <= load_sec;
          state    <= RUN;
          busy     <= 1'b1;
        end else begin
          // Zero duration expires immediately without entering RUN
          sec_left <= '0;
          done     <= 1'b1;
          state    <= IDLE;
          busy     <= 1'b0;
        end
      end else if (state == RUN && presc_tick) begin
        tick_1hz <= 1'b1;
        if (sec_left == SEC_W'(1)) begin
          done <= 1'b1;
          if (auto_reload) begin
            sec_left <= duration;
          end else begin
            sec_left <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end else begin
          sec_left <= sec_left - SEC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Directed self-checking bench for interval_timer at CLK_HZ=4, SEC_W=4.
module tb_interval_timer;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned SEC_W  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [SEC_W-1:0] load_sec;
  logic             auto_reload;
  logic             pause;
  logic             busy;
  logic             done;
  logic             tick_1hz;
  logic [SEC_W-1:0] sec_left;

  int checks = 0;
  int errors = 0;

  interval_timer #(
    .CLK_HZ(CLK_HZ),
    .SEC_W (SEC_W)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .start      (start),
    .load_sec   (load_sec),
    .auto_reload(auto_reload),
    .pause      (pause),
    .busy       (busy),
    .done       (done),
    .tick_1hz   (tick_1hz),
    .sec_left   (sec_left)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic b, input logic d,
                           input logic t, input int s);
    check({tag, ".busy"},     32'(busy),     32'(b));
    check({tag, ".done"},     32'(done),     32'(d));
    check({tag, ".tick_1hz"}, 32'(tick_1hz), 32'(t));
    check({tag, ".sec_left"}, 32'(sec_left), 32'(s));
  endtask

  initial begin
    int eff;
    logic busy_e;
    logic tk;
    logic dn;
    int sl;

    reset = 1'b1; start = 1'b0; load_sec = '0; auto_reload = 1'b0; pause = 1'b0;
    step();
    step();
    check_all("reset", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step();
      check_all("idle", 1'b0, 1'b0, 1'b0, 0);
    end

    // 3 s one-shot
    start = 1'b1; load_sec = 4'd3;
    step();
    start = 1'b0;
    check_all("oneshot_load", 1'b1, 1'b0, 1'b0, 3);
    for (int j = 1; j <= 16; j++) begin
      step();
      tk = (j % 4 == 0) && (j <= 12);
      sl = (j >= 12) ? 0 : 3 - j / 4;
      check_all("oneshot", j < 12, j == 12, tk, sl);
    end

    // 2 s auto-reload
    auto_reload = 1'b1; start = 1'b1; load_sec = 4'd2;
    step();
    start = 1'b0;
    check_all("reload_load", 1'b1, 1'b0, 1'b0, 2);
    for (int j = 1; j <= 40; j++) begin
      step();
      sl = ((j / 4) % 2 == 0) ? 2 : 1;
      check_all("reload", 1'b1, j % 8 == 0, j % 4 == 0, sl);
    end

    // Reset mid-run
    reset = 1'b1;
    step();
    check_all("mid_reset", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0; auto_reload = 1'b0;
    step();
    check_all("post_reset", 1'b0, 1'b0, 1'b0, 0);

    // 2 s with a 5-cycle pause starting at cycle 2
    start = 1'b1; load_sec = 4'd2;
    step();
    start = 1'b0;
    eff = 0; busy_e = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      pause = (j >= 2 && j <= 6);
      step();
      tk = 1'b0;
      if (!pause && busy_e) begin
        eff++;
        tk = (eff % 4 == 0);
      end
      dn = tk && (eff == 8);
      if (dn) busy_e = 1'b0;
      sl = busy_e ? 2 - eff / 4 : 0;
      check_all("pause", busy_e, dn, tk, sl);
    end
    pause = 1'b0;

    // 3 s run restarted at cycle 6 with 1 s
    start = 1'b1; load_sec = 4'd3;
    step();
    start = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      if (j == 6) begin
        start = 1'b1; load_sec = 4'd1;
      end
      step();
      start = 1'b0;
      sl = (j < 4) ? 3 : (j < 6) ? 2 : (j < 10) ? 1 : 0;
      check_all("restart", j < 10, j == 10, j == 4 || j == 10, sl);
    end

    // Zero-duration start from IDLE
    start = 1'b1; load_sec = 4'd0;
    step();
    start = 1'b0;
    check_all("zero_start", 1'b0, 1'b1, 1'b0, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      check_all("zero_after", 1'b0, 1'b0, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
# interval_timer

Parametrised, single-clock successor to the fixed 5 s / 10 s light-phase counters. It counts a run-time programmable number of seconds derived from the system clock, then emits a one-cycle `done` pulse. It supports pause, restart and auto-reload. All logic runs on `CLOCK_50` with clock-enable ticks, with no derived or rippled clocks. The intersection phase controller instantiates one per phase sequencer.

## Interface
- `CLK_HZ`, 50_000_000, input clock cycles per second; must be ≥ 2.
- `SEC_W`, 6, width of duration and remaining-seconds fields; maximum duration is 2^SEC_W−1 s.
- `CLOCK_50`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  single-cycle request: latch `load_sec` and (re)start timing.
- `load_sec`  input  SEC_W  duration in seconds; sampled only when `start`=1.
- `auto_reload`  input  1  level; when 1 at expiry, reload the latched duration and keep running.
- `pause`  input  1  level; freezes prescaler and seconds count while 1.
- `busy`  output  1  1 while in RUN.
- `done`  output  1  one-cycle pulse at expiry.
- `tick_1hz`  output  1  one-cycle pulse at each elapsed second while running.
- `sec_left`  output  SEC_W  remaining whole seconds.

## Operation
- Reset: state IDLE; prescaler=0; `sec_left`=0; latched duration=0; `busy`=`done`=`tick_1hz`=0. Reset overrides all inputs in the same cycle.
- States: IDLE, RUN.
- IDLE, `start`=1, `load_sec`≠0: latch duration; `sec_left`←`load_sec`; prescaler←0; go to RUN.
- IDLE, `start`=1, `load_sec`=0: no RUN. `done`=1 for the next cycle; stay IDLE.
- RUN, `start`=1: restart. Same load as from IDLE, including a zero-duration `done` with return to IDLE. Any expiry coinciding in that cycle is discarded and produces no `done`.
- RUN, `pause`=1 and no `start`: prescaler, `sec_left` and state hold; no `tick_1hz`.
- RUN, unpaused: prescaler increments modulo CLK_HZ. When the prescaler is CLK_HZ−1, a tick occurs:
  - prescaler←0
  - `tick_1hz`=1 next cycle
  - `sec_left` decrements
- Expiry happens on a tick with `sec_left`=1:
  - `sec_left`←0, `done`=1 next cycle.
  - `auto_reload`=0: go to IDLE.
  - `auto_reload`=1: `sec_left`←latched duration; stay RUN. Counting continues without a gap.
- `start` together with `pause`: load is performed. Counting begins once `pause` drops.
- Prescaler width is clog2(CLK_HZ). The wrap compare is exact (CLK_HZ−1), with no off-by-one.
- `sec_left` never underflows; it is 0 whenever in IDLE after expiry.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- A `start` sampled at edge k gives `busy`=1 and `sec_left`=N from edge k.
- With no pause, `tick_1hz` pulses follow edges k+j·CLK_HZ for j=1..N. `done` coincides with the Nth tick pulse.
- Each paused cycle delays all subsequent ticks by exactly one cycle.
- `busy` falls on the same edge at which `done` rises, unless auto-reloading.
- `done` and `tick_1hz` are exactly one cycle wide. With auto_reload, consecutive `done` pulses are exactly N·CLK_HZ cycles apart.

## Structure
- Shared package `intersection_pkg` holds:
  - the state enum (IDLE, RUN)
  - `CLK_HZ_DEFAULT` = 50_000_000
  - phase-duration constants (5, 10 s) used by the phase controller
- Sub-module `tick_prescaler`, parameters CLK_HZ:
  - inputs: `CLOCK_50`, `reset`, `clr`, `en`
  - output: `tick`
  - modulo-CLK_HZ counter, cleared by `clr`, advancing when `en`
- The seconds counter and state machine live in `interval_timer`.

## Test plan
All scenarios use CLK_HZ=4, SEC_W=4.
- Reset then idle: hold 20 cycles → `busy`=`done`=`tick_1hz`=0, `sec_left`=0.
- `start`, `load_sec`=3, `auto_reload`=0 → `tick_1hz` at cycles 4, 8, 12 after start, with `sec_left` 2, 1, 0. `done` coincides with the third tick. `busy` falls the same cycle; no further pulses.
- `load_sec`=2, `auto_reload`=1, run 40 cycles → `done` every 8 cycles; `busy` stays 1; `sec_left` cycles 2→1→2.
- `load_sec`=2, `pause` high for 5 cycles starting cycle 2 → `done` at cycle 13 instead of 8. `sec_left` is constant during the pause.
- Restart at cycle 6 of a 3 s run with `load_sec`=1 → `sec_left`=1 from cycle 6. `done` at cycle 10; the original expiry never appears.
- `start` with `load_sec`=0 → `done`=1 for one cycle, `busy` never asserts. Separately, assert `reset` mid-run → all outputs return to reset values on the next edge.
